conv_rd_stream: RTL and testbench
=================================

// Module: conv_rd_stream
// PURPOSE
//  AXI4 read master that feeds the conv datapath inside ConvWrapper's axi_bus_t port.
//  - On start, fetches num_beats 64 B beats from base_addr as AR bursts.
//  - Bursts never exceed MAX_BURST beats and never cross a 4 KB page.
//  - Returned R beats are forwarded in order as a valid/ready stream to the conv core.
// PARAMETERS
//  ADDR_W     64   AXI address width
//  DATA_W     512  AXI data width (one beat = 64 B)
//  ID_W       16   AXI ID width
//  MAX_BURST  64   max beats per AR burst (arlen <= MAX_BURST-1)
//  MAX_OUTST  8    max AR bursts outstanding without final rlast
//  ARID_VAL   0    constant ID driven on arid
// PORTS
//  clk        in   1       user clock
//  rst        in   1       synchronous active-high reset
//  start      in   1       1-cycle pulse: begin job (ignored while busy)
//  base_addr  in   ADDR_W  job start byte address; bits [5:0] forced to 0
//  num_beats  in   32      job length in beats
//  busy       out  1       job in progress
//  done       out  1       1-cycle pulse at job completion
//  err        out  1       sticky: any rresp!=OKAY this job
//  arid       out  ID_W    = ARID_VAL
//  araddr     out  ADDR_W  burst address
//  arlen      out  8       beats-1
//  arsize     out  3       constant 3'b110 (64 B)
//  arvalid    out  1
//  arready    in   1
//  rid        in   ID_W    ignored (single ID, in-order)
//  rdata      in   DATA_W
//  rresp      in   2
//  rlast      in   1
//  rvalid     in   1
//  rready     out  1
//  out_data   out  DATA_W  beat to conv core
//  out_last   out  1       final beat of job
//  out_valid  out  1
//  out_ready  in   1
// BEHAVIOUR
//  - Reset: all outputs 0, including arsize register/arid if registered.
//    - FSM -> IDLE; counters cleared.
//    - Reset is applied only with the shell/interconnect reset, so no stale R beats arrive.
//  - FSM: IDLE -start&num_beats>0-> ISSUE; ISSUE -last AR handshake-> DRAIN;
//    DRAIN -final beat accepted on out-> DONE; DONE -> IDLE (done=1 for that cycle).
//    - start with num_beats==0: IDLE->DONE directly; done the next cycle, no AR issued.
//  - Burst length = min(remaining, MAX_BURST, (4096 - addr[11:0])/64).
//    - Computed combinationally from registered cur_addr/remaining.
//    - After each AR handshake: cur_addr += len*64; remaining -= len.
//    - Addresses wrap modulo 2^ADDR_W with no special handling.
//  - arvalid asserted in ISSUE only while outst < MAX_OUTST.
//    - Once asserted, held with araddr/arlen stable until arready.
//  - outst counter:
//    - +1 on AR handshake.
//    - -1 on R handshake with rlast.
//    - Both in the same cycle: unchanged. Never exceeds MAX_OUTST.
//  - R->out path: 2-entry skid buffer, so rready is registered (not combinationally from out_ready).
//    - Full throughput: 1 beat/cycle when out_ready=1.
//    - Latency: 1 cycle from rvalid to out_valid.
//    - out_* held stable while out_valid & !out_ready.
//  - out_last = 1 on beat number num_beats of the job (beat counter, not rlast).
//  - busy = 1 from the cycle after accepted start until the done cycle inclusive.
//  - err cleared on accepted start; set on any R handshake with rresp!=0.
//    - Data is still forwarded when err is set.
// STRUCTURE
//  - Package conv_pkg: BEAT_BYTES=64, PAGE_BYTES=4096, AXI_SIZE_64B=3'b110,
//    typedef enum {IDLE,ISSUE,DRAIN,DONE} rd_state_t.
//    - Also function burst_beats(addr,remaining,max) for the min rule.
//  - One sub-module: conv_skid_buf #(W) (2-entry valid/ready skid buffer).
//    - Reusable by the write side.
// TESTING
//  1. base=0x1000, num_beats=4, arready/out_ready=1.
//     -> one AR araddr=0x1000 arlen=3; 4 out beats, out_last on 4th; done pulse; err=0.
//  2. base=0x0FC0, num_beats=3.
//     -> AR 0x0FC0 len0, then AR 0x1000 len1 (page split); out data order preserved.
//  3. base=0, num_beats=200, MAX_BURST=64.
//     -> arlen sequence 63,63,63,7; addrs 0,0x1000,0x2000,0x3000.
//  4. R slave withholds rvalid; num_beats=640.
//     -> exactly MAX_OUTST=8 AR accepted, then arvalid=0 until first rlast.
//  5. out_ready toggled randomly, rresp=SLVERR on beat 2, num_beats=10.
//     -> no beat lost or duplicated; err=1 sticky until next start.
//  6. start with num_beats=0 -> done 1 cycle later, no arvalid.
//     rst mid-job -> all outputs 0 next cycle.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared constants, FSM state type and burst sizing helper for the conv AXI read/write streamers.
package conv_pkg;

    localparam int unsigned BEAT_BYTES   = 64;
    localparam int unsigned BEAT_SHIFT   = $clog2(BEAT_BYTES);
    localparam int unsigned PAGE_BYTES   = 4096;
    localparam logic [2:0]  AXI_SIZE_64B = 3'b110;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        DONE
    } rd_state_t;

    // Beats for the next burst: limited by what is left, the burst cap and the 4 KB page edge.
    // addr is the page offset of a beat-aligned address, so the page term is 1..64.
    function automatic logic [31:0] burst_beats(
        input logic [11:0] addr,
        input logic [31:0] remaining,
        input logic [31:0] max_beats
    );
        logic [31:0] page_left;
        logic [31:0] len;
        page_left = (PAGE_BYTES - {20'd0, addr}) >> BEAT_SHIFT;
        len = remaining;
        if (max_beats < len) len = max_beats;
        if (page_left < len) len = page_left;
        return len;
    endfunction

endpackage

// File: rtl/conv_rd_stream_if.sv
// Job control, AXI AR/R channels and the output beat stream of the conv read streamer.
interface conv_rd_stream_if #(
    parameter int unsigned ADDR_W = 64,
    parameter int unsigned DATA_W = 512,
    parameter int unsigned ID_W   = 16
);
    // job control
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [31:0]       num_beats;
    logic              busy;
    logic              done;
    logic              err;
    // AXI read address channel
    logic [ID_W-1:0]   arid;
    logic [ADDR_W-1:0] araddr;
    logic [7:0]        arlen;
    logic [2:0]        arsize;
    logic              arvalid;
    logic              arready;
    // AXI read data channel
    logic [ID_W-1:0]   rid;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rlast;
    logic              rvalid;
    logic              rready;
    // beat stream to the conv core
    logic [DATA_W-1:0] out_data;
    logic              out_last;
    logic              out_valid;
    logic              out_ready;

    modport master (
        input  start, base_addr, num_beats,
        output busy, done, err,
        output arid, araddr, arlen, arsize, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready,
        output out_data, out_last, out_valid,
        input  out_ready
    );

    modport slave (
        output start, base_addr, num_beats,
        input  busy, done, err,
        input  arid, araddr, arlen, arsize, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready,
        input  out_data, out_last, out_valid,
        output out_ready
    );

endinterface

// File: rtl/conv_skid_buf.sv
// Two-entry valid/ready skid buffer: registered outputs and a registered in_ready,
// still sustaining one transfer per cycle while out_ready stays high.
module conv_skid_buf #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic         out_valid_q, out_valid_n;
    logic [W-1:0] out_data_q, out_data_n;
    logic         skid_valid_q, skid_valid_n;
    logic [W-1:0] skid_data_q, skid_data_n;
    logic         in_ready_q;
    logic         in_fire;

    assign in_fire   = in_valid & in_ready_q;
    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

    // Next state: the output slot refills from the skid entry first, otherwise straight
    // from the input; the skid entry only catches a beat that arrives while the output stalls.
    always_comb begin
        out_valid_n  = out_valid_q;
        out_data_n   = out_data_q;
        skid_valid_n = skid_valid_q;
        skid_data_n  = skid_data_q;
        if (!out_valid_q || out_ready) begin
            if (skid_valid_q) begin
                out_valid_n  = 1'b1;
                out_data_n   = skid_data_q;
                skid_valid_n = 1'b0;
            end else begin
                out_valid_n = in_fire;
                if (in_fire) out_data_n = in_data;
            end
        end else if (in_fire) begin
            skid_valid_n = 1'b1;
            skid_data_n  = in_data;
        end
    end

    // Register both entries; in_ready is precomputed from the next skid occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            in_ready_q   <= 1'b0;
        end else begin
            out_valid_q  <= out_valid_n;
            out_data_q   <= out_data_n;
            skid_valid_q <= skid_valid_n;
            skid_data_q  <= skid_data_n;
            in_ready_q   <= !skid_valid_n;
        end
    end

endmodule

// File: rtl/conv_rd_stream.sv
// AXI4 read master: splits a job into page-safe bursts, limits outstanding bursts
// and forwards returned beats in order to the conv core through a skid buffer.
module conv_rd_stream
    import conv_pkg::*;
#(
    parameter int unsigned ADDR_W    = 64,
    parameter int unsigned DATA_W    = 512,
    parameter int unsigned ID_W      = 16,
    parameter int unsigned MAX_BURST = 64,
    parameter int unsigned MAX_OUTST = 8,
    parameter int unsigned ARID_VAL  = 0
) (
    input  logic             clk,
    input  logic             rst,
    conv_rd_stream_if.master bus
);

    localparam int unsigned OW = $clog2(MAX_OUTST + 1);

    rd_state_t         state;
    logic [ADDR_W-1:0] cur_addr;
    logic [31:0]       remaining;
    logic [31:0]       total;
    logic [31:0]       beat_cnt;
    logic [OW-1:0]     outst;

    logic              arvalid_q;
    logic [ADDR_W-1:0] araddr_q;
    logic [7:0]        arlen_q;
    logic [2:0]        arsize_q;
    logic [ID_W-1:0]   arid_q;
    logic              busy_q;
    logic              done_q;
    logic              err_q;

    logic [31:0]       burst_len;
    logic [31:0]       ar_beats;
    logic [ADDR_W-1:0] ar_step;
    logic              ar_fire;
    logic              r_fire;
    logic              rready;
    logic              r_is_last;
    logic              o_valid;
    logic [DATA_W:0]   o_word;
    logic              o_fire;
    logic              unused_bits;

    assign unused_bits = ^{bus.rid, bus.base_addr[BEAT_SHIFT-1:0]};

    // Next burst size from the registered address/remaining count, and the advance
    // applied when the currently presented burst is accepted.
    always_comb begin
        burst_len = burst_beats(cur_addr[11:0], remaining, 32'(MAX_BURST));
        ar_beats  = 32'(arlen_q) + 32'd1;
        ar_step   = ADDR_W'(ar_beats * BEAT_BYTES);
    end

    assign ar_fire   = arvalid_q & bus.arready;
    assign r_fire    = bus.rvalid & rready;
    assign r_is_last = (beat_cnt + 32'd1 == total);
    assign o_fire    = o_valid & bus.out_ready;

    // The job-final flag travels with the beat so it stays aligned through the buffer.
    conv_skid_buf #(.W(DATA_W + 1)) u_skid (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (bus.rvalid),
        .in_ready  (rready),
        .in_data   ({r_is_last, bus.rdata}),
        .out_valid (o_valid),
        .out_ready (bus.out_ready),
        .out_data  (o_word)
    );

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
    assign bus.arid      = arid_q;
    assign bus.araddr    = araddr_q;
    assign bus.arlen     = arlen_q;
    assign bus.arsize    = arsize_q;
    assign bus.arvalid   = arvalid_q;
    assign bus.rready    = rready;
    assign bus.out_valid = o_valid;
    assign bus.out_data  = o_word[DATA_W-1:0];
    assign bus.out_last  = o_word[DATA_W];

    // Job FSM with AR issue, outstanding-burst tracking, beat counting and status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cur_addr  <= '0;
            remaining <= '0;
            total     <= '0;
            beat_cnt  <= '0;
            outst     <= '0;
            arvalid_q <= 1'b0;
            araddr_q  <= '0;
            arlen_q   <= '0;
            arsize_q  <= '0;
            arid_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            arid_q   <= ID_W'(ARID_VAL);
            arsize_q <= AXI_SIZE_64B;
            done_q   <= 1'b0;

            if (ar_fire && !(r_fire && bus.rlast)) begin
                outst <= outst + OW'(1);
            end else if (!ar_fire && r_fire && bus.rlast) begin
                outst <= outst - OW'(1);
            end

            if (r_fire) begin
                beat_cnt <= beat_cnt + 32'd1;
                if (bus.rresp != 2'b00) err_q <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (bus.start) begin
                        err_q     <= 1'b0;
                        beat_cnt  <= '0;
                        total     <= bus.num_beats;
                        remaining <= bus.num_beats;
                        cur_addr  <= {bus.base_addr[ADDR_W-1:BEAT_SHIFT], {BEAT_SHIFT{1'b0}}};
                        busy_q    <= 1'b1;
                        if (bus.num_beats == '0) begin
                            state  <= DONE;
                            done_q <= 1'b1;
                        end else begin
                            state <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    // cur_addr/remaining advance only on acceptance, so arlen_q+1 equals the
                    // burst_len that was latched when arvalid rose.
                    if (ar_fire) begin
                        arvalid_q <= 1'b0;
                        cur_addr  <= cur_addr + ar_step;
                        remaining <= remaining - ar_beats;
                        if (remaining == ar_beats) state <= DRAIN;
                    end else if (!arvalid_q && (outst < OW'(MAX_OUTST))) begin
                        arvalid_q <= 1'b1;
                        araddr_q  <= cur_addr;
                        arlen_q   <= 8'(burst_len - 32'd1);
                    end
                end
                DRAIN: begin
                    if (o_fire && o_word[DATA_W]) begin
                        state  <= DONE;
                        done_q <= 1'b1;
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_conv_rd_stream.sv
// Directed bench for conv_rd_stream with an in-order AXI read slave model.
module tb_conv_rd_stream;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    conv_rd_stream_if #(.ADDR_W(64), .DATA_W(512), .ID_W(16)) bus ();

    conv_rd_stream #(
        .ADDR_W(64), .DATA_W(512), .ID_W(16),
        .MAX_BURST(64), .MAX_OUTST(8), .ARID_VAL(0)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    int total_n = 0;
    int bad_n   = 0;

    logic [63:0] q_addr[$];
    int          q_len[$];
    logic [63:0] ar_log_addr[$];
    int          ar_log_len[$];
    int          head_beat = 0;
    int          r_idx = 0;
    int          err_beat = -1;
    int          out_cnt = 0;
    int          exp_n = 0;
    logic [63:0] exp_base = '0;
    int unsigned job_id = 0;
    bit          done_seen = 0;
    bit          r_en = 1;
    bit          o_rdy_rand = 0;

    function automatic logic [511:0] mkdata(input logic [63:0] a, input int unsigned job);
        return {job, 384'd0, ~a[31:0], a};
    endfunction

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        total_n++;
        assert (obs === exp) else begin
            bad_n++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // One clock: drive slave/sink inputs, sample handshakes just before the edge,
    // then update the slave model and check any beat delivered to the core.
    task automatic tick();
        bit ar_f, r_f, r_l, o_f, ol;
        logic [63:0]  aa;
        logic [511:0] od;
        int al;
        bus.arready   = 1'b1;
        bus.out_ready = o_rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        if (r_en && q_addr.size() > 0) begin
            bus.rvalid = 1'b1;
            bus.rdata  = mkdata(q_addr[0] + 64'(head_beat) * 64, job_id);
            bus.rlast  = (head_beat == q_len[0]);
            bus.rresp  = (r_idx == err_beat) ? 2'b10 : 2'b00;
        end else begin
            bus.rvalid = 1'b0;
            bus.rdata  = '0;
            bus.rlast  = 1'b0;
            bus.rresp  = 2'b00;
        end
        #3;
        ar_f = bus.arvalid && bus.arready;
        aa   = bus.araddr;
        al   = int'(bus.arlen);
        r_f  = bus.rvalid && bus.rready;
        r_l  = bus.rlast;
        o_f  = bus.out_valid && bus.out_ready;
        od   = bus.out_data;
        ol   = bus.out_last;
        @(posedge clk);
        #1;
        if (ar_f) begin
            q_addr.push_back(aa);
            q_len.push_back(al);
            ar_log_addr.push_back(aa);
            ar_log_len.push_back(al);
        end
        if (r_f) begin
            r_idx++;
            if (r_l) begin
                void'(q_addr.pop_front());
                void'(q_len.pop_front());
                head_beat = 0;
            end else begin
                head_beat++;
            end
        end
        if (o_f) begin
            chk("out_data", od, mkdata(exp_base + 64'(out_cnt) * 64, job_id));
            chk("out_last", 512'(ol), 512'(out_cnt == exp_n - 1));
            out_cnt++;
        end
        if (bus.done) done_seen = 1;
    endtask

    task automatic start_job(input logic [63:0] base, input int n);
        job_id++;
        exp_base = base & ~64'h3F;
        exp_n = n;
        out_cnt = 0;
        r_idx = 0;
        done_seen = 0;
        ar_log_addr.delete();
        ar_log_len.delete();
        bus.base_addr = base;
        bus.num_beats = 32'(n);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic run_job(input string tag, input logic [63:0] base, input int n, input int budget);
        start_job(base, n);
        chk({tag, "_busy"}, 512'(bus.busy), 512'(1));
        for (int c = 0; c < budget && !done_seen; c++) tick();
        chk({tag, "_done"}, 512'(done_seen), 512'(1));
        chk({tag, "_beats"}, 512'(out_cnt), 512'(n));
        tick();
        chk({tag, "_idle"}, 512'({bus.busy, bus.done}), 512'(0));
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"}, 512'(bus.busy), 512'(0));
        chk({tag, "_done"}, 512'(bus.done), 512'(0));
        chk({tag, "_err"}, 512'(bus.err), 512'(0));
        chk({tag, "_ar"}, 512'({bus.arvalid, bus.arid, bus.arsize, bus.arlen, bus.araddr}), 512'(0));
        chk({tag, "_rready"}, 512'(bus.rready), 512'(0));
        chk({tag, "_out"}, 512'({bus.out_valid, bus.out_last}), 512'(0));
        chk({tag, "_odata"}, bus.out_data, 512'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        bus.start = 1'b0;
        bus.base_addr = '0;
        bus.num_beats = '0;
        bus.rid = '0;
        bus.arready = 1'b0;
        bus.rvalid = 1'b0;
        bus.rdata = '0;
        bus.rlast = 1'b0;
        bus.rresp = 2'b00;
        bus.out_ready = 1'b0;
        @(posedge clk);
        #1;
        tick();
        tick();
        chk_zero("reset");
        rst = 1'b0;
        tick();
        chk("rready_up", 512'(bus.rready), 512'(1));
        chk("arsize", 512'(bus.arsize), 512'(3'b110));

        // single burst
        run_job("j1", 64'h1000, 4, 100);
        chk("j1_nar", 512'(ar_log_addr.size()), 512'(1));
        chk("j1_ar0", 512'({ar_log_addr[0], 8'(ar_log_len[0])}), 512'({64'h1000, 8'd3}));
        chk("j1_err", 512'(bus.err), 512'(0));

        // page split
        run_job("j2", 64'h0FC0, 3, 100);
        chk("j2_nar", 512'(ar_log_addr.size()), 512'(2));
        chk("j2_ar0", 512'({ar_log_addr[0], 8'(ar_log_len[0])}), 512'({64'h0FC0, 8'd0}));
        chk("j2_ar1", 512'({ar_log_addr[1], 8'(ar_log_len[1])}), 512'({64'h1000, 8'd1}));

        // burst cap
        run_job("j3", 64'h0, 200, 1000);
        chk("j3_nar", 512'(ar_log_addr.size()), 512'(4));
        chk("j3_ar0", 512'({ar_log_addr[0], 8'(ar_log_len[0])}), 512'({64'h0000, 8'd63}));
        chk("j3_ar1", 512'({ar_log_addr[1], 8'(ar_log_len[1])}), 512'({64'h1000, 8'd63}));
        chk("j3_ar2", 512'({ar_log_addr[2], 8'(ar_log_len[2])}), 512'({64'h2000, 8'd63}));
        chk("j3_ar3", 512'({ar_log_addr[3], 8'(ar_log_len[3])}), 512'({64'h3000, 8'd7}));

        // backpressured sink with an error response on the second beat
        o_rdy_rand = 1;
        err_beat = 1;
        run_job("j5", 64'h2000, 10, 400);
        o_rdy_rand = 0;
        err_beat = -1;
        chk("j5_err", 512'(bus.err), 512'(1));
        tick();
        tick();
        chk("j5_err_sticky", 512'(bus.err), 512'(1));

        // zero-length job: done on the next cycle, no AR, err cleared
        start_job(64'h5000, 0);
        chk("z_done", 512'({bus.done, bus.busy}), 512'(2'b11));
        chk("z_err_clr", 512'(bus.err), 512'(0));
        chk("z_noar", 512'(bus.arvalid), 512'(0));
        tick();
        chk("z_done_off", 512'({bus.done, bus.busy, bus.arvalid}), 512'(0));
        chk("z_nar", 512'(ar_log_addr.size()), 512'(0));

        // outstanding limit with the R channel withheld
        r_en = 0;
        start_job(64'h0, 640);
        for (int c = 0; c < 40; c++) tick();
        chk("ol_nar", 512'(ar_log_addr.size()), 512'(8));
        chk("ol_arvalid", 512'(bus.arvalid), 512'(0));
        chk("ol_ar7", 512'(ar_log_addr[7]), 512'(64'h7000));
        r_en = 1;
        for (int c = 0; c < 300 && ar_log_addr.size() < 9; c++) tick();
        chk("ol_nar9", 512'(ar_log_addr.size()), 512'(9));
        chk("ol_after_rlast", 512'(r_idx >= 64), 512'(1));
        chk("ol_ar8", 512'(ar_log_addr[8]), 512'(64'h8000));

        // reset mid-job
        rst = 1'b1;
        tick();
        chk_zero("midrst");
        rst = 1'b0;
        q_addr.delete();
        q_len.delete();
        head_beat = 0;
        tick();
        tick();

        // recovery
        run_job("j7", 64'h0040, 2, 100);
        chk("j7_ar0", 512'({ar_log_addr[0], 8'(ar_log_len[0])}), 512'({64'h0040, 8'd1}));

        $display("test done: total=%0d bad=%0d", total_n, bad_n);
        $finish;
    end

endmodule
